// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned WDOG_LIMIT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // D wins a tie unless it also won the previous grant, so fetches cannot starve.
  function automatic logic grant_to_d(input logic d_req, input logic i_ok, input logic last_grant);
    return d_req & (~i_ok | (last_grant != GRANT_D));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side (I/D) and memory-side handshake bundle of the memory arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_kill;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              if_stall;
  logic              mem_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  logic              wdog_err;

  modport slave (
    input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, if_stall, mem_stall,
           m_req, m_we, m_addr, m_wdata, wdog_err
  );

  modport master (
    output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, if_stall, mem_stall,
           m_req, m_we, m_addr, m_wdata, wdog_err
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Transaction watchdog: counts busy cycles without m_ack and flags a sticky timeout.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = WDOG_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_busy,
  input  logic i_m_ack,
  output logic o_abort,
  output logic o_err
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Abort on the edge that would bring the count up to LIMIT.
  assign o_abort = i_busy & ~i_m_ack & (r_cnt == CNT_W'(LIMIT - 1));
  assign o_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_busy & ~i_m_ack & ~o_abort) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (o_abort) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction
// at a time. Define MEM_ARB_WDOG_EN to abort transactions outstanding for WDOG_LIMIT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  if (WDOG_LIMIT == 0) begin : g_bad_limit
    $error("mem_arbiter: WDOG_LIMIT must be nonzero");
  end

  arb_state_e        r_state;
  logic              r_last_grant;
  logic              r_kill_pend;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_i_ok;
  logic w_grant;
  logic w_grant_d;
  logic w_busy;
  logic w_done;
  logic w_i_drop;
  logic w_abort;

  assign w_i_ok    = bus.i_req & ~bus.i_kill;
  assign w_grant   = (r_state == IDLE) & (bus.d_req | w_i_ok);
  assign w_grant_d = grant_to_d(bus.d_req, w_i_ok, r_last_grant);
  assign w_busy    = (r_state != IDLE);
  assign w_done    = w_busy & (bus.m_ack | w_abort);
  // A kill landing on the completion edge still suppresses the fetch.
  assign w_i_drop  = r_kill_pend | bus.i_kill;

`ifdef MEM_ARB_WDOG_EN
  mem_arb_wdog #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_grant),
    .i_busy  (w_busy),
    .i_m_ack (bus.m_ack),
    .o_abort (w_abort),
    .o_err   (bus.wdog_err)
  );
`else
  assign w_abort      = 1'b0;
  assign bus.wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
      r_kill_pend  <= 1'b0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_m_req      <= 1'b1;
            r_last_grant <= w_grant_d;
            if (w_grant_d) begin
              r_state   <= D_BUSY;
              r_m_we    <= bus.d_we;
              r_m_addr  <= bus.d_addr;
              r_m_wdata <= bus.d_wdata;
            end else begin
              r_state  <= I_BUSY;
              r_m_we   <= 1'b0;
              r_m_addr <= bus.i_addr;
            end
          end
        end
        I_BUSY: begin
          if (w_done) begin
            r_state     <= IDLE;
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_kill_pend <= 1'b0;
            if (!w_i_drop) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= w_abort ? '0 : bus.m_rdata;
            end
          end else if (bus.i_kill) begin
            r_kill_pend <= 1'b1;
          end
        end
        D_BUSY: begin
          if (w_done) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
            r_m_we  <= 1'b0;
            r_d_ack <= 1'b1;
            if (w_abort) begin
              r_d_rdata <= '0;
            end else if (!r_m_we) begin
              r_d_rdata <= bus.m_rdata;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req     = r_m_req;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_stall  = bus.i_req & ~r_i_ack;
  assign bus.mem_stall = bus.d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions plus hand-written contention, kill,
// reset and (with MEM_ARB_WDOG_EN) watchdog sequences, checked through two scoreboards.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 8;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WDOG_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;
    logic [31:0] exp_rdata;
  } vec_t;

  ack_exp_t    ack_q[$];
  mem_exp_t    mem_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          mem_wait = 0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] exp_i_rdata = 32'h0;
  vec_t        vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  // Memory model: acks after mem_wait extra cycles and checks the request against mem_q.
  initial begin
    int       cnt;
    mem_exp_t cur;
    cnt         = 0;
    cur         = '0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.m_req) begin
        cnt       = 0;
        bus.m_ack = 1'b0;
      end else begin
        if (cnt == 0) begin
          check("m_req_expected", {31'd0, mem_q.size() != 0}, 32'd1);
          if (mem_q.size() != 0) begin
            cur = mem_q.pop_front();
            check("m_we", {31'd0, bus.m_we}, {31'd0, cur.we});
            check("m_addr", bus.m_addr, cur.addr);
            if (cur.we) check("m_wdata", bus.m_wdata, cur.wdata);
          end
        end else begin
          check("m_hold_we", {31'd0, bus.m_we}, {31'd0, cur.we});
          check("m_hold_addr", bus.m_addr, cur.addr);
          if (cur.we) check("m_hold_wdata", bus.m_wdata, cur.wdata);
        end
        if (cnt == mem_wait) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_rdata;
        end else begin
          bus.m_ack   = 1'b0;
          bus.m_rdata = ~mem_rdata;
        end
        cnt++;
      end
    end
  end

  // Ack monitor: every ack must match the oldest expected completion.
  initial begin
    ack_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.i_ack) begin
        check("i_ack_order", {31'd0, ack_q.size() != 0 && ack_q[0].port == GRANT_I}, 32'd1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("i_rdata", bus.i_rdata, e.rdata);
          exp_i_rdata = e.rdata;
        end
      end
      if (bus.d_ack) begin
        check("d_ack_order", {31'd0, ack_q.size() != 0 && ack_q[0].port == GRANT_D}, 32'd1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("d_rdata", bus.d_rdata, e.rdata);
        end
      end
    end
  end

  task automatic do_txn(input string name, input logic port, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input int waits,
                        input logic [31:0] exp_rd, input int exp_lat);
    int   lat;
    logic stall_ok;
    logic ack;
    logic stall;
    mem_wait  = waits;
    mem_rdata = mrd;
    mem_q.push_back('{we: port & we, addr: addr, wdata: wdata});
    ack_q.push_back('{port: port, rdata: exp_rd});
    if (port == GRANT_D) begin
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_req   = 1'b1;
    end else begin
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
    end
    lat      = -1;
    stall_ok = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      ack   = port ? bus.d_ack : bus.i_ack;
      stall = port ? bus.mem_stall : bus.if_stall;
      if (ack) begin
        lat = k;
        check({name, "_stall_in_ack"}, {31'd0, stall}, 32'd0);
        break;
      end
      if (!stall) stall_ok = 1'b0;
    end
    check({name, "_stall_wait"}, {31'd0, stall_ok}, 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (port == GRANT_D) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nd;
    int ni;
    vecs[0] = '{GRANT_D, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, 32'h1234_5678};
    vecs[1] = '{GRANT_D, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 32'hDEAD_BEEF, 3, 32'h1234_5678};
    vecs[2] = '{GRANT_I, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0013, 0, 32'h0000_0013};
    vecs[3] = '{GRANT_I, 1'b0, 32'h0000_0104, 32'h0, 32'hFFFF_0000, 2, 32'hFFFF_0000};
    vecs[4] = '{GRANT_D, 1'b0, 32'h0000_0200, 32'h0, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5};
    vecs[5] = '{GRANT_D, 1'b1, 32'h0000_0204, 32'h0000_0001, 32'h0, 0, 32'hA5A5_A5A5};
    vecs[6] = '{GRANT_I, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h89AB_CDEF, 5, 32'h89AB_CDEF};

    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.i_kill  = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    #12;
    check("rst_m_req", {31'd0, bus.m_req}, 32'd0);
    check("rst_m_we", {31'd0, bus.m_we}, 32'd0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
    check("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_wdog_err", {31'd0, bus.wdog_err}, 32'd0);
    check("rst_if_stall", {31'd0, bus.if_stall}, 32'd0);

    // Contention: both ports request from reset release and re-request after each ack.
    bus.i_addr = 32'h0000_0100;
    bus.d_addr = 32'h0000_0200;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    mem_wait   = 0;
    mem_rdata  = 32'h0BAD_CAFE;
    for (int r = 0; r < 2; r++) begin
      mem_q.push_back('{we: 1'b0, addr: 32'h0000_0200, wdata: 32'h0});
      mem_q.push_back('{we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0});
      ack_q.push_back('{port: GRANT_D, rdata: 32'h0BAD_CAFE});
      ack_q.push_back('{port: GRANT_I, rdata: 32'h0BAD_CAFE});
    end
    #1;
    check("rst_if_stall_req", {31'd0, bus.if_stall}, 32'd1);
    check("rst_mem_stall_req", {31'd0, bus.mem_stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    ni = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.d_ack) nd++;
      if (bus.i_ack) ni++;
      if (nd == 2) bus.d_req = 1'b0;
      if (ni == 2) bus.i_req = 1'b0;
      if (nd == 2 && ni == 2) break;
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    check("cont_d_acks", 32'(nd), 32'd2);
    check("cont_i_acks", 32'(ni), 32'd2);

    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].mrdata, vecs[i].waits, vecs[i].exp_rdata, vecs[i].waits + 2);
    end

    // Kill together with the request in IDLE: no grant.
    bus.i_addr = 32'h0000_0044;
    bus.i_req  = 1'b1;
    bus.i_kill = 1'b1;
    @(posedge clk);
    #1;
    check("kill_idle_no_grant", {31'd0, bus.m_req}, 32'd0);
    bus.i_req  = 1'b0;
    bus.i_kill = 1'b0;

    // Kill while the fetch is in flight: memory completes, no i_ack, i_rdata kept.
    mem_wait  = 3;
    mem_rdata = 32'h7777_7777;
    mem_q.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0});
    bus.i_addr = 32'h0000_0010;
    bus.i_req  = 1'b1;
    @(posedge clk);
    #1;
    check("kill_busy_granted", {31'd0, bus.m_req}, 32'd1);
    bus.i_kill = 1'b1;
    bus.i_req  = 1'b0;
    @(posedge clk);
    #1;
    bus.i_kill = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.m_req) break;
      @(posedge clk);
      #1;
    end
    check("kill_m_req_done", {31'd0, bus.m_req}, 32'd0);
    check("kill_no_i_ack", {31'd0, bus.i_ack}, 32'd0);
    check("kill_i_rdata_kept", bus.i_rdata, exp_i_rdata);
    do_txn("after_kill", GRANT_D, 1'b0, 32'h0000_0048, 32'h0, 32'h1357_9BDF, 1,
           32'h1357_9BDF, 3);

    // Reset in the middle of a store: everything clears at once.
    mem_wait  = 1000;
    mem_rdata = 32'h0;
    mem_q.push_back('{we: 1'b1, addr: 32'h0000_03C0, wdata: 32'h5555_AAAA});
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_03C0;
    bus.d_wdata = 32'h5555_AAAA;
    bus.d_req   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, bus.m_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_req", {31'd0, bus.m_req}, 32'd0);
    check("midrst_m_we", {31'd0, bus.m_we}, 32'd0);
    check("midrst_m_addr", bus.m_addr, 32'h0);
    check("midrst_m_wdata", bus.m_wdata, 32'h0);
    check("midrst_d_ack", {31'd0, bus.d_ack}, 32'd0);
    check("midrst_d_rdata", bus.d_rdata, 32'h0);
    check("midrst_i_rdata", bus.i_rdata, 32'h0);
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    exp_i_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn("after_rst", GRANT_I, 1'b0, 32'h0000_0020, 32'h0, 32'h600D_600D, 1,
           32'h600D_600D, 3);

`ifdef MEM_ARB_WDOG_EN
    do_txn("wdog_abort", GRANT_D, 1'b0, 32'h0000_0300, 32'h0, 32'hFEED_FACE, 1000,
           32'h0, int'(LIMIT) + 1);
    check("wdog_err_set", {31'd0, bus.wdog_err}, 32'd1);
    do_txn("wdog_after", GRANT_I, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_0BB0, 0,
           32'h0000_0BB0, 2);
    check("wdog_err_sticky", {31'd0, bus.wdog_err}, 32'd1);
`else
    check("wdog_err_tied", {31'd0, bus.wdog_err}, 32'd0);
`endif

    @(posedge clk);
    #1;
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
